// File: rtl/layer_sequencer_if.sv
// Handshake, configuration and status bundle between the layer sequencer and its
// surroundings: descriptor port, engine and weight-loader handshakes, run control.
interface layer_sequencer_if #(
    parameter int unsigned MAX_LAYERS = 16,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned WADDR_W    = 9
);
    localparam int unsigned LW = $clog2(MAX_LAYERS);

    logic               cfg_we;
    logic [LW-1:0]      cfg_addr;
    logic [19:0]        cfg_data;
    logic [LW:0]        layer_count;
    logic               GO;
    logic               wld_req;
    logic               wld_done;
    logic               eng_start;
    logic [1:0]         eng_op;
    logic               eng_done;
    logic [ADDR_W-1:0]  src_addr;
    logic [ADDR_W-1:0]  dst_addr;
    logic [WADDR_W-1:0] w_addr;
    logic [4:0]         matrix;
    logic               bias;
    logic               globmaxp_en;
    logic [3:0]         res_in;
    logic [3:0]         RESULT;
    logic               busy;
    logic               STOP;

    // Sequencer side
    modport master (
        input  cfg_we, cfg_addr, cfg_data, layer_count, GO, wld_done, eng_done, res_in,
        output wld_req, eng_start, eng_op, src_addr, dst_addr, w_addr, matrix, bias,
        output globmaxp_en, RESULT, busy, STOP
    );

    // Host / engine side
    modport slave (
        output cfg_we, cfg_addr, cfg_data, layer_count, GO, wld_done, eng_done, res_in,
        input  wld_req, eng_start, eng_op, src_addr, dst_addr, w_addr, matrix, bias,
        input  globmaxp_en, RESULT, busy, STOP
    );
endinterface

// File: rtl/layer_sequencer.sv
// Descriptor-driven CNN layer sequencer: walks the descriptor table, issues one engine
// start per pass with its source/destination/weight bases, ping-pongs the pixel buffers.
module layer_sequencer #(
    parameter int unsigned MAX_LAYERS = 16,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned WADDR_W    = 9,
    parameter int unsigned GROUP      = 4,
    parameter int unsigned BUF_A      = 0,
    parameter int unsigned BUF_B      = 3136
) (
    input logic               clk,
    input logic               rst,
    layer_sequencer_if.master bus
);
    localparam int unsigned LW = $clog2(MAX_LAYERS);

    localparam logic [1:0] OpConv   = 2'd0;
    localparam logic [1:0] OpMaxp   = 2'd1;
    localparam logic [1:0] OpResult = 2'd3;
    localparam logic [1:0] OpDense  = 2'd2;

    typedef enum logic [2:0] {StIdle, StFetch, StWload, StIssue, StRun, StNext, StFin} state_e;

    state_e state_q, state_d;

    logic [19:0]        desc_mem [MAX_LAYERS];
    logic [19:0]        desc_q, desc_d;
    logic [LW:0]        lcount_q, lcount_d, layer_q, layer_d, layer_inc;
    logic [4:0]         g_q, g_d, o_q, o_d;
    logic [WADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0]  src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [ADDR_W-1:0]  src_q, dst_q, src_c, dst_c;
    logic [WADDR_W-1:0] w_addr_q;
    logic [1:0]         op_q;
    logic               bias_q, gmp_q, busy_q, stop_q, layer_end;
    logic [3:0]         result_q;
    logic [9:0]         m2_d;
    logic [ADDR_W-1:0]  m2_a, g_a, o_a;

    // Descriptor table write port; deliberately not cleared by rst
    always_ff @(posedge clk) begin
        if (bus.cfg_we) desc_mem[bus.cfg_addr] <= bus.cfg_data;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Last pass of the current layer (latched descriptor and loop counters)
    always_comb begin
        layer_inc = layer_q + 1'b1;
        case (desc_q[1:0])
            OpConv:  layer_end = (g_q == desc_q[6:2]) && (o_q == desc_q[11:7]);
            OpMaxp:  layer_end = (o_q == desc_q[11:7]);
            default: layer_end = 1'b1;
        endcase
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.GO) state_d = (bus.layer_count == '0) ? StFin : StFetch;
            StFetch: state_d = desc_d[18] ? StWload : StIssue;
            StWload: if (bus.wld_done) state_d = StIssue;
            StIssue: state_d = StRun;
            StRun:   if (bus.eng_done) state_d = StNext;
            StNext: begin
                if (!layer_end)                 state_d = StIssue;
                else if (layer_inc == lcount_q) state_d = StFin;
                else                            state_d = StFetch;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Loop counters, buffer bases and next-pass address computation
    always_comb begin
        desc_d     = desc_q;
        lcount_d   = lcount_q;
        layer_d    = layer_q;
        g_d        = g_q;
        o_d        = o_q;
        w_ptr_d    = w_ptr_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        case (state_q)
            StIdle: begin
                if (bus.GO) begin
                    lcount_d   = bus.layer_count;
                    layer_d    = '0;
                    g_d        = '0;
                    o_d        = '0;
                    w_ptr_d    = '0;
                    src_base_d = ADDR_W'(BUF_A);
                    dst_base_d = ADDR_W'(BUF_B);
                end
            end
            StFetch: desc_d = desc_mem[layer_q[LW-1:0]];
            StNext: begin
                if (desc_q[1:0] == OpConv || desc_q[1:0] == OpDense) w_ptr_d = w_ptr_q + 1'b1;
                if (desc_q[1:0] == OpConv) begin
                    if (g_q == desc_q[6:2]) begin
                        g_d = '0;
                        o_d = o_q + 1'b1;
                    end else begin
                        g_d = g_q + 1'b1;
                    end
                end
                if (desc_q[1:0] == OpMaxp) o_d = o_q + 1'b1;
                if (layer_end) begin
                    g_d     = '0;
                    o_d     = '0;
                    layer_d = layer_inc;
                    if (!desc_q[19]) begin
                        src_base_d = dst_base_q;
                        dst_base_d = src_base_q;
                    end
                end
            end
            default: ;
        endcase

        // Addresses use next-state values so they are registered on entry to ISSUE
        m2_d = 10'(desc_d[16:12]) * 10'(desc_d[16:12]);
        m2_a = ADDR_W'(m2_d);
        g_a  = ADDR_W'(g_d);
        o_a  = ADDR_W'(o_d);
        case (desc_d[1:0])
            OpConv: begin
                src_c = src_base_d + g_a * ADDR_W'(GROUP) * m2_a;
                dst_c = desc_d[17] ? dst_base_d + o_a : dst_base_d + o_a * m2_a;
            end
            OpMaxp: begin
                src_c = src_base_d + o_a * m2_a;
                dst_c = dst_base_d + o_a * (m2_a >> 2);
            end
            default: begin
                src_c = src_base_d;
                dst_c = dst_base_d;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_q     <= '0;
            lcount_q   <= '0;
            layer_q    <= '0;
            g_q        <= '0;
            o_q        <= '0;
            w_ptr_q    <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            w_addr_q   <= '0;
            op_q       <= OpConv;
            bias_q     <= 1'b0;
            gmp_q      <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            result_q   <= 4'hF;
        end else begin
            desc_q     <= desc_d;
            lcount_q   <= lcount_d;
            layer_q    <= layer_d;
            g_q        <= g_d;
            o_q        <= o_d;
            w_ptr_q    <= w_ptr_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            if (state_d == StIssue) begin
                src_q    <= src_c;
                dst_q    <= dst_c;
                w_addr_q <= w_ptr_d;
                op_q     <= desc_d[1:0];
                bias_q   <= (desc_d[1:0] == OpConv) && (g_d == desc_d[6:2]);
                gmp_q    <= (desc_d[1:0] == OpConv) && desc_d[17];
            end
            if (state_q == StIdle && bus.GO) begin
                stop_q   <= 1'b0;
                result_q <= 4'hF;
                busy_q   <= (bus.layer_count != '0);
            end
            if (state_q == StRun && bus.eng_done && op_q == OpResult) result_q <= bus.res_in;
            // Later assignment wins so a zero-layer GO still ends with STOP set
            if (state_d == StFin) begin
                stop_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    // Output decode
    always_comb begin
        bus.eng_start   = (state_q == StIssue);
        bus.wld_req     = (state_q == StWload);
        bus.eng_op      = op_q;
        bus.src_addr    = src_q;
        bus.dst_addr    = dst_q;
        bus.w_addr      = w_addr_q;
        bus.matrix      = desc_q[16:12];
        bus.bias        = bias_q;
        bus.globmaxp_en = gmp_q;
        bus.RESULT      = result_q;
        bus.busy        = busy_q;
        bus.STOP        = stop_q;
    end
endmodule
